// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multi-cycle CPU control unit with run/halt/single-step.
//
// Each instruction walks FETCH -> DECODE -> EXEC. From HALT the unit starts
// either continuous execution (run level) or one instruction (rising edge
// of step). It also counts retired instructions.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   run          level, continuous execution while 1
//   step         single-step request, rising edge only
//   opcode[5:0]  instruction bits [15:10]
//   z            zero flag
//   we_ir        instruction-register write enable (FETCH)
//   we_pc        program-counter write enable (EXEC)
//   s_inc        PC source: 1 = PC+1, 0 = jump target
//   s_inm        register write-data source: 1 = immediate, 0 = ALU
//   we3          register-file write enable
//   wez          zero-flag write enable
//   op_alu[2:0]  ALU operation
//   halted       1 while in HALT
//   state[1:0]   HALT=00, FETCH=01, DECODE=10, EXEC=11
//   instr_count  retired-instruction counter, wraps
//
// state  | meaning
// -------+---------------------------------------------------------
// HALT   | idle, no write enables; waits for run or a step edge
// FETCH  | instruction register loads
// DECODE | opcode is latched into op_q
// EXEC   | PC and datapath writes happen, instruction retires

module uc_multiciclo #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [5:0]       opcode,
  input  logic             z,
  output logic             we_ir,
  output logic             we_pc,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    HALT   = 2'b00,
    FETCH  = 2'b01,
    DECODE = 2'b10,
    EXEC   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [5:0]       op_q;
  logic             step_q;
  logic             single;
  logic [CNT_W-1:0] count_q;
  logic             step_edge;

  assign step_edge = step & ~step_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HALT;
      op_q    <= 6'b000000;
      step_q  <= 1'b0;
      single  <= 1'b0;
      count_q <= '0;
    end else begin
      step_q <= step;
      case (state_q)
        HALT: begin
          // run has priority over a coincident step edge
          if (run) begin
            state_q <= FETCH;
            single  <= 1'b0;
          end else if (step_edge) begin
            state_q <= FETCH;
            single  <= 1'b1;
          end
        end
        FETCH: state_q <= DECODE;
        DECODE: begin
          op_q    <= opcode;
          state_q <= EXEC;
        end
        EXEC: begin
          count_q <= count_q + CNT_ONE;
          if (run && !single) begin
            state_q <= FETCH;
          end else begin
            state_q <= HALT;
            single  <= 1'b0;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

  // Outputs decode only registered state plus z, so reset removes every
  // write enable immediately.
  always_comb begin
    we_ir  = (state_q == FETCH);
    we_pc  = 1'b0;
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    op_alu = 3'b000;
    if (state_q == EXEC) begin
      we_pc = 1'b1;
      casez (op_q)
        6'b001000: s_inc = 1'b0;
        6'b001001: s_inc = z;
        6'b0000??: begin
          s_inm = 1'b1;
          we3   = 1'b1;
        end
        6'b1?????: begin
          we3    = 1'b1;
          wez    = 1'b1;
          op_alu = op_q[4:2];
        end
        default: ;  // NOP: PC still advances
      endcase
    end
  end

  assign halted      = (state_q == HALT);
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo (CNT_W=4 so counter wrap is reachable).
// Stimulus pushes the expected EXEC control vector per instruction; a
// monitor pops and compares each time we_pc presents an EXEC cycle.
module tb_uc_multiciclo;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, run, step, z;
  logic [5:0]    opcode;
  logic          we_ir, we_pc, s_inc, s_inm, we3, wez, halted;
  logic [2:0]    op_alu;
  logic [1:0]    state;
  logic [CW-1:0] instr_count;

  uc_multiciclo #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .opcode(opcode), .z(z),
    .we_ir(we_ir), .we_pc(we_pc), .s_inc(s_inc), .s_inm(s_inm), .we3(we3),
    .wez(wez), .op_alu(op_alu), .halted(halted), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          s_inc;
    logic          s_inm;
    logic          we3;
    logic          wez;
    logic [2:0]    op_alu;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void push(input logic si, input logic sm, input logic w3,
                               input logic wz, input logic [2:0] alu,
                               input int c);
    exp_t e;
    e.s_inc = si; e.s_inm = sm; e.we3 = w3; e.wez = wz; e.op_alu = alu;
    e.cnt = CW'(c);
    exp_q.push_back(e);
  endfunction

  // Monitor: an EXEC cycle is marked by we_pc.
  always @(negedge clk) begin
    if (reset && we_pc) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL exec_unexpected: got EXEC at %0t expected none queued", $time);
      end else begin
        exp_t e, a;
        e = exp_q.pop_front();
        a.s_inc = s_inc; a.s_inm = s_inm; a.we3 = we3; a.wez = wez;
        a.op_alu = op_alu; a.cnt = instr_count;
        n_total++;
        if (a == e) n_pass++;
        else $display("FAIL exec_ctl: got si/sm/we3/wez/alu/cnt=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                      a.s_inc, a.s_inm, a.we3, a.wez, a.op_alu, a.cnt,
                      e.s_inc, e.s_inm, e.we3, e.wez, e.op_alu, e.cnt);
        check("exec_state_weir", {state, we_ir}, {2'b11, 1'b0});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int st_exp[5];
    st_exp = '{1, 2, 3, 0, 0};
    reset = 1'b0; run = 1'b0; step = 1'b0; opcode = 6'd0; z = 1'b0;
    repeat (2) cyc();
    check("rst_state", state, 0);
    check("rst_halted", halted, 1);
    check("rst_we", {we_ir, we_pc, we3, wez}, 0);
    check("rst_s_inc", s_inc, 1);
    check("rst_s_inm_alu", {s_inm, op_alu}, 0);
    check("rst_count", instr_count, 0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_state", {state, halted}, 3'b001);
      check("idle_we", {we_ir, we_pc, we3, wez, s_inc}, 5'b00001);
    end
    check("idle_count", instr_count, 0);

    // Continuous run of A+B, three instructions
    opcode = 6'b101000;
    push(1, 0, 1, 1, 3'b010, 0);
    push(1, 0, 1, 1, 3'b010, 1);
    push(1, 0, 1, 1, 3'b010, 2);
    run = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      check("run_state", state, ((i - 1) % 3) + 1);
      check("run_we_ir", we_ir, (((i - 1) % 3) == 0) ? 1 : 0);
    end
    run = 1'b0;
    cyc();
    check("run_end_state", state, 0);
    check("run_end_count", instr_count, 3);

    // Conditional jump, single step with step held high 5 cycles, z=0
    opcode = 6'b001001; z = 1'b0;
    push(0, 0, 0, 0, 3'b000, 3);
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("step_hold_state", state, st_exp[i]);
    end
    step = 1'b0;
    cyc();
    check("step1_state", state, 0);
    check("step1_count", instr_count, 4);

    // Second step, z=1
    z = 1'b1;
    push(1, 0, 0, 0, 3'b000, 4);
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("step2_fetch", state, 1);
    cyc();
    cyc();
    cyc();
    check("step2_state", state, 0);
    check("step2_count", instr_count, 5);
    z = 1'b0;

    // Load immediate then undefined opcode
    opcode = 6'b000011;
    push(1, 1, 1, 0, 3'b000, 5);
    push(1, 0, 0, 0, 3'b000, 6);
    run = 1'b1;
    repeat (3) cyc();
    opcode = 6'b010101;
    repeat (3) cyc();
    run = 1'b0;
    cyc();
    check("linop_state", state, 0);
    check("linop_count", instr_count, 7);

    // Drop run during FETCH: instruction still completes
    opcode = 6'b101100;
    push(1, 0, 1, 1, 3'b011, 7);
    run = 1'b1;
    cyc();
    check("drop_fetch", state, 1);
    run = 1'b0;
    cyc();
    check("drop_decode", state, 2);
    cyc();
    check("drop_exec", state, 3);
    cyc();
    check("drop_halt", state, 0);
    check("drop_count", instr_count, 8);

    // Reset asserted during EXEC
    opcode = 6'b101000;
    push(1, 0, 1, 1, 3'b010, 8);
    run = 1'b1;
    repeat (3) cyc();
    #2 reset = 1'b0;
    #1;
    check("rexec_we", {we3, we_pc, wez, we_ir}, 0);
    check("rexec_state", state, 0);
    check("rexec_count", instr_count, 0);
    run = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    check("rexec_after", state, 0);

    // Sixteen instructions: counter wraps 1111 -> 0000
    opcode = 6'b111100;
    for (int k = 0; k < 16; k++) push(1, 0, 1, 1, 3'b111, k);
    run = 1'b1;
    repeat (48) cyc();
    check("wrap_pre", instr_count, 15);
    run = 1'b0;
    cyc();
    check("wrap_state", state, 0);
    check("wrap_count", instr_count, 0);

    // run and step edge in the same HALT cycle: run wins
    opcode = 6'b101000;
    push(1, 0, 1, 1, 3'b010, 0);
    push(1, 0, 1, 1, 3'b010, 1);
    run = 1'b1; step = 1'b1;
    cyc();
    step = 1'b0;
    check("both_fetch", state, 1);
    cyc();
    cyc();
    cyc();
    check("both_continue", state, 1);
    cyc();
    cyc();
    run = 1'b0;
    cyc();
    check("both_halt", state, 0);
    check("both_count", instr_count, 2);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
